// File: rtl/melbank_reader.sv
// melbank_reader
//   Drain-side sequencer for the mel accumulator register file. After a
//   frame's accumulation, it reads bands 0..NBANDS-1 in order. Each band is
//   presented downstream as a registered valid/ready beat. The block drives
//   the bank port only while busy; the integration muxes the port on busy.
//
// Optional build macro: MELBANK_CLEAR_EN
//   When defined, each band is written back to zero right after its
//   handshake, using a one-cycle CLR state. This leaves the bank clean for
//   the next frame.
//   When undefined, there is no CLR state, regmel_wren stays 0 and the bank
//   contents survive readout.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-high reset
//   start         one-cycle readout request, honoured only in IDLE
//   busy          block owns the bank port (READ/WAIT/OUT/CLR)
//   done          one-cycle pulse after the final band handshake
//   regmel_wren   bank write enable (CLR state only)
//   regmel_addr   bank address = current band index (0 in IDLE)
//   regmel_wdata  bank write data, constant 0
//   regmel_in     bank registered read data
//   mel_data      band value, registered
//   mel_idx       band index of mel_data
//   mel_valid     stream valid
//   mel_ready     stream ready from downstream
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | bank port released; wait for start
// READ  | present idx to the bank (read cycle)
// WAIT  | bank data valid; capture into the output register
// OUT   | hold the beat until mel_valid & mel_ready
// CLR   | (MELBANK_CLEAR_EN) write 0 to band idx, then advance
module melbank_reader #(
  parameter int NBANDS = 23,
  parameter int DATA_W = 44,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              regmel_wren,
  output logic [ADDR_W-1:0] regmel_addr,
  output logic [DATA_W-1:0] regmel_wdata,
  input  logic [DATA_W-1:0] regmel_in,
  output logic [DATA_W-1:0] mel_data,
  output logic [ADDR_W-1:0] mel_idx,
  output logic              mel_valid,
  input  logic              mel_ready
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_WAIT = 3'd2,
    S_OUT  = 3'd3
`ifdef MELBANK_CLEAR_EN
    ,S_CLR = 3'd4
`endif
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NBANDS - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic              done_nxt;
  logic              load_beat;
  logic              drop_beat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      done      <= 1'b0;
      mel_data  <= '0;
      mel_idx   <= '0;
      mel_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      done  <= done_nxt;
      if (load_beat) begin
        mel_data  <= regmel_in;
        mel_idx   <= idx;
        mel_valid <= 1'b1;
      end else if (drop_beat) begin
        mel_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    done_nxt  = 1'b0;
    load_beat = 1'b0;
    drop_beat = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_READ;
          idx_nxt   = '0;
        end
      end
      S_READ: state_nxt = S_WAIT;
      S_WAIT: begin
        load_beat = 1'b1;
        state_nxt = S_OUT;
      end
      S_OUT: begin
        if (mel_valid && mel_ready) begin
          drop_beat = 1'b1;
`ifdef MELBANK_CLEAR_EN
          state_nxt = S_CLR;
`else
          if (idx == LAST_IDX) begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
          end else begin
            idx_nxt   = idx + ADDR_W'(1);
            state_nxt = S_READ;
          end
`endif
        end
      end
`ifdef MELBANK_CLEAR_EN
      S_CLR: begin
        if (idx == LAST_IDX) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end else begin
          idx_nxt   = idx + ADDR_W'(1);
          state_nxt = S_READ;
        end
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Port outputs decode straight from state, so an asynchronous reset
  // releases the bank port immediately, without waiting for an edge.
  assign busy         = (state != S_IDLE);
  assign regmel_addr  = (state == S_IDLE) ? '0 : idx;
  assign regmel_wdata = '0;
`ifdef MELBANK_CLEAR_EN
  assign regmel_wren  = (state == S_CLR);
`else
  assign regmel_wren  = 1'b0;
`endif

endmodule

// File: doc/melbank_reader.md
Name: melbank_reader

Overview:
Drain-side sequencer for the 23-band mel accumulator register file.
- After a frame's accumulation finishes, it takes over the bank's address/write-enable port.
- It reads bands 0..NBANDS-1 in order and presents each band as a registered valid/ready stream to the next stage (log/DCT).
- It is the reader counterpart of the accumulate-writer path. It owns the bank only while busy; the integration muxes the bank port on busy.

Parameters:
NBANDS, 23, number of mel bands read per frame
DATA_W, 44, accumulator word width
ADDR_W, 5, bank address width; 2^ADDR_W >= NBANDS

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to read out the bank; sampled in IDLE only
busy  out  1  high in READ/WAIT/OUT/CLR states; integration gives bank port to this block when high
done  out  1  one-cycle pulse after final band handshake
regmel_wren  out  1  bank write enable; 0 except in CLR state
regmel_addr  out  ADDR_W  bank address = current band index
regmel_wdata  out  DATA_W  bank write data; constant 0
regmel_in  in  DATA_W  bank read data (bank's registered output)
mel_data  out  DATA_W  band value, registered
mel_idx  out  ADDR_W  band index of mel_data
mel_valid  out  1  stream valid
mel_ready  in  1  stream ready from downstream

Behaviour:
- Reset (async, immediate):
  - state=IDLE; idx=0.
  - All outputs 0: busy, done, regmel_wren, regmel_addr, mel_data, mel_idx, mel_valid.
  - Bank contents are not touched.
- Bank timing:
  - The address presented with wren=0 during cycle N is sampled at the end of N.
  - regmel_in is valid during N+1 and holds while wren=0 and addr is unchanged.
- FSM:
  - IDLE: start=1 -> READ, idx=0. regmel_addr=0, wren=0.
  - READ: regmel_addr=idx, wren=0 -> WAIT.
  - WAIT: regmel_addr=idx. At the edge, mel_data<=regmel_in, mel_idx<=idx, mel_valid<=1 -> OUT.
  - OUT:
    - Hold mel_data, mel_idx and mel_valid stable until mel_valid & mel_ready at an edge.
    - On handshake, mel_valid<=0.
    - Then, if idx=NBANDS-1 -> IDLE with done<=1 for one cycle; else idx<=idx+1 -> READ.
    - With the optional feature enabled, go to CLR instead (see Optional Feature).
- Latency:
  - start at edge k -> mel_valid first high in cycle k+3.
  - Minimum 3 cycles per band; 4 with clear.
- Back-to-back: no bubble insertion beyond the FSM cycles; mel_ready high continuously gives 1 beat per 3 cycles.
- Boundaries:
  - start while busy is ignored.
  - start in the same cycle as the done pulse is accepted (state is IDLE).
  - idx never exceeds NBANDS-1 and never wraps within a run.
  - mel_ready asserted without mel_valid has no effect.
  - Data passes through unmodified, full DATA_W width, unsigned.
- Reset mid-run: abort immediately; the next start restarts at band 0. Partially cleared bank (feature on) is accepted.

Optional Feature:
Macro MELBANK_CLEAR_EN.
- Defined:
  - After each OUT handshake, enter CLR for one cycle: regmel_addr=idx, regmel_wren=1, regmel_wdata=0.
  - Then advance: idx+1 -> READ, or for the last band -> IDLE with done.
  - Result: the bank is zeroed for the next frame's accumulation.
- Undefined:
  - No CLR state; regmel_wren is constant 0.
  - Bank contents survive readout.

Test Plan:
1. Preload band i = 1000*i+7; pulse start with mel_ready=1 -> 23 beats, mel_idx 0..22, mel_data 7,1007,...,22007; first valid 3 cycles after start; done single pulse after beat 22; busy low afterwards.
2. Same preload; hold mel_ready=0 for 5 cycles while band 4 is presented -> mel_data=4007, mel_idx=4 stable throughout; next beat is band 5; no skip or duplicate.
3. Pulse start again at band 10 while busy -> ignored, exactly 23 beats. start pulsed in the done cycle -> second full run, values repeat (feature off).
4. Assert reset asynchronously while band 10 is in OUT -> all outputs 0 before the next edge; state IDLE. Next start -> beats resume from band 0.
5. MELBANK_CLEAR_EN defined, preload as test 1 -> first run correct values, wren pulses at addr 0..22 with data 0; second run returns 23 zeros. Undefined -> wren never 1, second run equals first.
6. Band 22 = 2^44-1, band 0 = 0 -> delivered unchanged, idx 22 last, no truncation.
